// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for the 5-stage RV32I core: stage flush/bubble control,
// EX operand forwarding, data-cache miss freeze FSM and performance counters.
module hazard_stall_controller #(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       reg1_srcD,
    input  logic [4:0]       reg2_srcD,
    input  logic [4:0]       reg1_srcE,
    input  logic [4:0]       reg2_srcE,
    input  logic [4:0]       reg_dstE,
    input  logic [4:0]       reg_dstM,
    input  logic [4:0]       reg_dstW,
    input  logic             wb_select_E,
    input  logic             reg_write_en_M,
    input  logic             reg_write_en_W,
    input  logic             br_E,
    input  logic             jalr_E,
    input  logic             jal_D,
    input  logic             mem_access_M,
    input  logic             cache_miss,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic [1:0]       op1_sel,
    output logic [1:0]       op2_sel,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             miss_timeout
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int                WAIT_W    = $clog2(MISS_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MISS_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MISS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [0:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_miss_count;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              r_miss_timeout;

    logic w_miss_start;
    logic w_miss_stall;
    logic w_load_use;
    logic w_ctrl_xfer;
    logic w_load_bubble;

    // The freeze lasts exactly as long as cache_miss is high: the cycle the
    // line arrives is the release cycle, so the pipe advances on that edge.
    assign w_miss_start  = (r_state == RUN) && mem_access_M && cache_miss;
    assign w_miss_stall  = cache_miss && ((r_state == WAIT) || mem_access_M);
    assign w_load_use    = wb_select_E && (reg_dstE != 5'd0) &&
                           ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));
    assign w_ctrl_xfer   = br_E || jalr_E;
    assign w_load_bubble = !w_miss_stall && w_load_use && !w_ctrl_xfer;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_write_en_M && (reg_dstM != 5'd0) && (reg_dstM == src))
            return 2'b01;
        else if (reg_write_en_W && (reg_dstW != 5'd0) && (reg_dstW == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        {flushF, flushD, flushE, flushM, flushW}      = 5'b00000;
        {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b00000;
        op1_sel = 2'b00;
        op2_sel = 2'b00;
        if (rst) begin
            {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
        end else begin
            op1_sel = fwd_sel(reg1_srcE);
            op2_sel = fwd_sel(reg2_srcE);
            if (w_miss_stall) begin
                {bubbleF, bubbleD, bubbleE, bubbleM} = 4'b1111;
                flushW = 1'b1;
            end else if (w_ctrl_xfer) begin
                // A taken transfer discards the ID instruction, so any load-use on it is moot.
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (w_load_use) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                flushE  = 1'b1;
            end else if (jal_D) begin
                flushD = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_miss_count   <= '0;
            r_stall_cycles <= '0;
            r_miss_timeout <= 1'b0;
        end else begin
            if (w_miss_stall || w_load_bubble)
                r_stall_cycles <= r_stall_cycles + CNT_ONE;

            if (r_state == RUN) begin
                r_wait_cnt <= '0;
                if (w_miss_start) begin
                    r_state      <= WAIT;
                    r_miss_count <= r_miss_count + CNT_ONE;
                end
            end else if (cache_miss) begin
                if (r_wait_cnt != WAIT_MAX)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                if (r_wait_cnt >= WAIT_LAST)
                    r_miss_timeout <= 1'b1;
            end else begin
                r_state    <= RUN;
                r_wait_cnt <= '0;
            end
        end
    end

    assign miss_count   = r_miss_count;
    assign stall_cycles = r_stall_cycles;
    assign miss_timeout = r_miss_timeout;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Drives per-stage flush/bubble (stall) signals and EX-stage operand forwarding selects, using the decoded control fields carried down the pipe.
- Owns a small FSM that freezes the pipeline while the data cache services a miss.
- Keeps performance counters and a sticky miss-timeout flag.

Parameters:
CNT_W, 32, width of the perf counters miss_count and stall_cycles (wrap on overflow)
MISS_TIMEOUT, 1024, consecutive WAIT cycles after which miss_timeout sets

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
reg1_srcD, reg2_srcD  in  5  rs1/rs2 of instruction in ID
reg1_srcE, reg2_srcE  in  5  rs1/rs2 of instruction in EX
reg_dstE, reg_dstM, reg_dstW  in  5  rd in EX/MEM/WB
wb_select_E  in  1  instruction in EX is a load
reg_write_en_M, reg_write_en_W  in  1  rd write enable in MEM/WB
br_E  in  1  branch in EX resolved taken
jalr_E  in  1  jalr in EX
jal_D  in  1  jal in ID
mem_access_M  in  1  load or store (nonzero cache_write_en) in MEM
cache_miss  in  1  data cache busy/miss; level, held until the line is ready
flushF, flushD, flushE, flushM, flushW  out  1  clear stage register to NOP on next edge
bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  out  1  hold stage register
op1_sel, op2_sel  out  2  EX operand source: 00 regfile, 01 MEM ALU result, 10 WB value
miss_count  out  CNT_W  number of RUN->WAIT transitions
stall_cycles  out  CNT_W  cycles spent in WAIT plus load-use bubble cycles
miss_timeout  out  1  sticky: WAIT exceeded MISS_TIMEOUT cycles

Behaviour:
- Reset (rst=1 at a clk edge):
  - state<=RUN; miss_count, stall_cycles, internal wait counter <= 0; miss_timeout <= 0.
  - While rst is high: all flush* = 1, all bubble* = 0, op*_sel = 00.
  - Reset mid-miss abandons WAIT immediately.
- Forwarding (combinational, every state). For op1 (op2 identical with reg2_srcE):
  - 01 if reg_write_en_M && reg_dstM!=0 && reg_dstM==reg1_srcE;
  - else 10 if reg_write_en_W && reg_dstW!=0 && reg_dstW==reg1_srcE;
  - else 00.
  - MEM has priority over WB. x0 never forwards.
- FSM states RUN, WAIT:
  - RUN->WAIT when mem_access_M && cache_miss; miss_count+1 on that edge.
  - WAIT->RUN on the first edge where cache_miss==0.
  - A back-to-back miss re-enters WAIT from RUN on the next qualifying cycle.
- Stall outputs, in priority order (combinational from state and inputs):
  1. Miss stall: applies when state==WAIT, or state==RUN && mem_access_M && cache_miss (zero-latency freeze on the detect cycle).
     - bubbleF/D/E/M=1, flushW=1; all other flush*=0.
     - Branch/jal/load-use actions are suppressed and re-evaluated after release, because the EX/ID contents are held.
  2. Load-use: wb_select_E && reg_dstE!=0 && (reg_dstE==reg1_srcD || reg_dstE==reg2_srcD).
     - bubbleF=1, bubbleD=1, flushE=1.
     - If br_E||jalr_E in the same cycle: flushD=1, flushE=1, no bubbles (the control transfer wins; the ID instruction is discarded).
  3. br_E||jalr_E: flushD=1, flushE=1.
  4. jal_D: flushD=1.
  5. Otherwise all flush/bubble = 0.
- stall_cycles: +1 on each edge where miss stall (rule 1) or load-use bubble (rule 2, not overridden) is active.
- Wait counter:
  - Counts consecutive cycles in WAIT; cleared on entry to RUN.
  - When it reaches MISS_TIMEOUT, miss_timeout<=1 and stays 1 until rst.
  - The stall continues regardless.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Forwarding: add x5 in MEM (reg_write_en_M=1, reg_dstM=5), reg1_srcE=5, reg_dstW=5 also writing -> op1_sel=01; reg_dstM=0 with reg1_srcE=0 -> op1_sel=00.
- Load-use: lw x3 in EX, reg2_srcD=3 -> bubbleF=bubbleD=flushE=1 for exactly 1 cycle; stall_cycles 0->1.
- Miss: mem_access_M=1, cache_miss high for 5 cycles -> same-cycle freeze, 5 cycles bubbleF..M=1 with flushW=1; miss_count=1; stall_cycles=5; release on the cycle cache_miss=0.
- Simultaneous: br_E=1 during a miss -> no flushD/E until release; first RUN cycle flushD=flushE=1.
- Timeout: MISS_TIMEOUT=4, cache_miss held 6 cycles -> miss_timeout rises after the 4th WAIT cycle and stays 1 after release; rst clears it.
- Reset mid-WAIT: assert rst on the 2nd miss cycle -> next cycle all flush=1, counters 0, state RUN; after rst falls with cache_miss=0, no bubbles.
